// File: rtl/jtag_cfg_tx.sv
`default_nettype none
// ============================================================================
// Module   : jtag_cfg_tx
// Purpose  : Host-side serialiser for the config link. Accepts one command
//            (w0, w1, fir_open) per valid/ready handshake, frames it as four
//            nibbles {HDR, w0, w1, 3'b000 + open} and shifts it MSB-first on
//            tdi with tms as the bit-valid strobe. A desync pulse precedes
//            every frame so the receiver can realign. Returned tdo bits are
//            collected and published on echo_data at frame end.
// Ports    : w_clk, w_rst           clock, asynchronous active-high reset
//            cmd_valid/cmd_ready    command handshake (ready only in IDLE)
//            cmd_w0, cmd_w1         coefficient nibbles
//            cmd_open               fir_open flag
//            tms, tdi, desync       serial link outputs (all registered)
//            tdo                    serial return from the receiver
//            busy, done             frame in progress / one-cycle end pulse
//            echo_data              last 16 tdo samples, first bit in [15]
// Revision : 1.0 - initial release
// ============================================================================
module jtag_cfg_tx #(
  parameter logic [3:0] HDR           = 4'hA,
  parameter int         DESYNC_CYCLES = 1,
  parameter int         GAP_CYCLES    = 0
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_w0,
  input  logic [3:0]  cmd_w1,
  input  logic        cmd_open,
  output logic        tms,
  output logic        tdi,
  output logic        desync,
  input  logic        tdo,
  output logic        busy,
  output logic        done,
  output logic [15:0] echo_data
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int                    c_dcnt_w    = (DESYNC_CYCLES > 1) ? $clog2(DESYNC_CYCLES) : 1;
  localparam logic [c_dcnt_w-1:0]   c_dcnt_load = c_dcnt_w'(DESYNC_CYCLES - 1);
  localparam logic [3:0]            c_gap_load  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam logic                  c_has_gap   = (GAP_CYCLES > 0);

  state_t              state_q, state_d;
  logic [15:0]         frame_q, frame_d;
  logic [3:0]          bit_q, bit_d;
  logic [c_dcnt_w-1:0] dcnt_q, dcnt_d;
  logic [3:0]          gcnt_q, gcnt_d;
  logic [15:0]         shreg_q, shreg_d;
  logic [15:0]         echo_q, echo_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                tms_q, tms_d;
  logic                tdi_q, tdi_d;
  logic                desync_q, desync_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state and counter logic. bit_q is the index of the bit currently
  // on the line; it counts 15 down to 0 once per frame.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    dcnt_d  = dcnt_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d = ST_SYNC;
          frame_d = {HDR, cmd_w0, cmd_w1, 3'b000, cmd_open};
          dcnt_d  = c_dcnt_load;
        end
      end
      ST_SYNC: begin
        if (dcnt_q == '0) begin
          state_d = ST_SHIFT;
          bit_d   = 4'd15;
        end else begin
          dcnt_d = dcnt_q - c_dcnt_w'(1);
        end
      end
      ST_SHIFT: begin
        if (bit_q == 4'd0) begin
          state_d = ST_DONE;
        end else begin
          bit_d = bit_q - 4'd1;
          // Indices 12, 8 and 4 close the 1st, 2nd and 3rd nibble; the
          // optional gap sits between nibbles, never after the last one.
          if (c_has_gap && (bit_q[1:0] == 2'b00)) begin
            state_d = ST_GAP;
            gcnt_d  = c_gap_load;
          end
        end
      end
      ST_GAP: begin
        if (gcnt_q == 4'd0) begin
          state_d = ST_SHIFT;
        end else begin
          gcnt_d = gcnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so that every output is a flop
  // and reflects the state the FSM occupies during the same cycle.
  always_comb begin
    shreg_d     = tms_q ? {shreg_q[14:0], tdo} : shreg_q;
    // The edge that enters DONE also takes the 16th sample, so publish the
    // freshly shifted value rather than the stale register.
    echo_d      = (state_d == ST_DONE) ? shreg_d : echo_q;
    cmd_ready_d = (state_d == ST_IDLE);
    desync_d    = (state_d == ST_SYNC);
    tms_d       = (state_d == ST_SHIFT);
    tdi_d       = tms_d & frame_d[bit_d];
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q     <= ST_IDLE;
      frame_q     <= 16'h0000;
      bit_q       <= 4'd0;
      dcnt_q      <= '0;
      gcnt_q      <= 4'd0;
      shreg_q     <= 16'h0000;
      echo_q      <= 16'h0000;
      cmd_ready_q <= 1'b1;
      tms_q       <= 1'b0;
      tdi_q       <= 1'b0;
      desync_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      bit_q       <= bit_d;
      dcnt_q      <= dcnt_d;
      gcnt_q      <= gcnt_d;
      shreg_q     <= shreg_d;
      echo_q      <= echo_d;
      cmd_ready_q <= cmd_ready_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      desync_q    <= desync_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign desync    = desync_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign echo_data = echo_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_cfg_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_cfg_tx
// Purpose  : Self-checking bench for jtag_cfg_tx. Two instances: dut_a with
//            default parameters, dut_b with GAP_CYCLES=2. Both run in tdo
//            loopback (tdo = tdi) so echo_data must equal the frame sent.
//            Expected frames go into a scoreboard queue at command time and
//            are popped when the cycle model predicts the done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_cfg_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_valid, a_ready, a_open, a_tms, a_tdi, a_desync, a_busy, a_done;
  logic [3:0]  a_w0, a_w1;
  logic [15:0] a_echo;
  logic        b_valid, b_ready, b_open, b_tms, b_tdi, b_desync, b_busy, b_done;
  logic [3:0]  b_w0, b_w1;
  logic [15:0] b_echo;

  jtag_cfg_tx dut_a (
    .w_clk(clk), .w_rst(rst),
    .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_w0(a_w0), .cmd_w1(a_w1), .cmd_open(a_open),
    .tms(a_tms), .tdi(a_tdi), .desync(a_desync), .tdo(a_tdi),
    .busy(a_busy), .done(a_done), .echo_data(a_echo)
  );

  jtag_cfg_tx #(.GAP_CYCLES(2)) dut_b (
    .w_clk(clk), .w_rst(rst),
    .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_w0(b_w0), .cmd_w1(b_w1), .cmd_open(b_open),
    .tms(b_tms), .tdi(b_tdi), .desync(b_desync), .tdo(b_tdi),
    .busy(b_busy), .done(b_done), .echo_data(b_echo)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] sb_a[$];
  logic [15:0] sb_b[$];
  logic [15:0] echo_a_exp = 16'h0000;
  logic [15:0] echo_b_exp = 16'h0000;

  function automatic logic [15:0] frame_of(logic [3:0] w0, logic [3:0] w1, logic op);
    return {4'hA, w0, w1, 3'b000, op};
  endfunction

  // Expected {cmd_ready, desync, tms, tdi, busy, done} during cycle k after
  // the accepting edge (k=1 is the first cycle after it).
  function automatic logic [5:0] model(int k, int dn, int gp, logic [15:0] f);
    int d;
    int j;
    int seg;
    int pos;
    d = dn + 16 + 3 * gp + 1;
    if (k <= 0 || k > d) return 6'b100000;
    if (k <= dn) return 6'b010010;
    if (k == d) return 6'b000011;
    j   = k - dn - 1;
    seg = 4 + gp;
    if ((j % seg) >= 4) return 6'b000010;
    pos = (j / seg) * 4 + (j % seg);
    return {3'b001, f[15 - pos], 2'b10};
  endfunction

  function automatic logic [5:0] obs_a();
    return {a_ready, a_desync, a_tms, a_tdi, a_busy, a_done};
  endfunction

  function automatic logic [5:0] obs_b();
    return {b_ready, b_desync, b_tms, b_tdi, b_busy, b_done};
  endfunction

  // Presents a command on dut_a and returns just after the accepting edge.
  task automatic send_a(input logic [3:0] w0, input logic [3:0] w1, input logic op);
    @(negedge clk);
    a_w0 = w0; a_w1 = w1; a_open = op; a_valid = 1'b1;
    sb_a.push_back(frame_of(w0, w1, op));
    @(posedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({obs_a(), a_echo} !== {6'b100000, 16'h0000})
      $display("FAIL reset_a got %b/%h want 100000/0000", obs_a(), a_echo);
    n_vec++;
    if ({obs_b(), b_echo} !== {6'b100000, 16'h0000})
      $display("FAIL reset_b got %b/%h want 100000/0000", obs_b(), b_echo);
    if ({obs_a(), a_echo} !== {6'b100000, 16'h0000}) n_bad++;
    if ({obs_b(), b_echo} !== {6'b100000, 16'h0000}) n_bad++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] f;
    logic [5:0]  e;
    f = frame_of(4'h3, 4'hC, 1'b1);
    send_a(4'h3, 4'hC, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) a_valid = 1'b0;
      e = model(k, 1, 0, f);
      if (e[0] && sb_a.size() > 0) echo_a_exp = sb_a.pop_front();
      n_vec++;
      if (obs_a() !== e) begin
        n_bad++;
        $display("FAIL basic_c%0d got %b want %b", k, obs_a(), e);
      end
      n_vec++;
      if (a_echo !== echo_a_exp) begin
        n_bad++;
        $display("FAIL basic_echo_c%0d got %h want %h", k, a_echo, echo_a_exp);
      end
    end
  endtask

  task automatic test_gap();
    logic [15:0] f;
    logic [5:0]  e;
    f = frame_of(4'hF, 4'h0, 1'b0);
    @(negedge clk);
    b_w0 = 4'hF; b_w1 = 4'h0; b_open = 1'b0; b_valid = 1'b1;
    sb_b.push_back(f);
    @(posedge clk);
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (k == 1) b_valid = 1'b0;
      e = model(k, 1, 2, f);
      if (e[0] && sb_b.size() > 0) echo_b_exp = sb_b.pop_front();
      n_vec++;
      if (obs_b() !== e) begin
        n_bad++;
        $display("FAIL gap_c%0d got %b want %b", k, obs_b(), e);
      end
      n_vec++;
      if (b_echo !== echo_b_exp) begin
        n_bad++;
        $display("FAIL gap_echo_c%0d got %h want %h", k, b_echo, echo_b_exp);
      end
    end
  endtask

  task automatic test_echo();
    logic [15:0] f;
    logic [5:0]  e;
    for (int n = 0; n < 2; n++) begin
      f = (n == 0) ? frame_of(4'h5, 4'hA, 1'b1) : frame_of(4'h1, 4'h2, 1'b0);
      if (n == 0) send_a(4'h5, 4'hA, 1'b1);
      else        send_a(4'h1, 4'h2, 1'b0);
      for (int k = 1; k <= 24; k++) begin
        @(negedge clk);
        if (k == 1) a_valid = 1'b0;
        e = model(k, 1, 0, f);
        if (e[0] && sb_a.size() > 0) echo_a_exp = sb_a.pop_front();
        n_vec++;
        if (obs_a() !== e) begin
          n_bad++;
          $display("FAIL echo_f%0d_c%0d got %b want %b", n, k, obs_a(), e);
        end
        n_vec++;
        if (a_echo !== echo_a_exp) begin
          n_bad++;
          $display("FAIL echo_hold_f%0d_c%0d got %h want %h", n, k, a_echo, echo_a_exp);
        end
      end
    end
  endtask

  task automatic test_ignore();
    logic [15:0] f;
    logic [5:0]  e;
    f = frame_of(4'h6, 4'h9, 1'b0);
    send_a(4'h6, 4'h9, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) a_valid = 1'b0;
      e = model(k, 1, 0, f);
      if (e[0] && sb_a.size() > 0) echo_a_exp = sb_a.pop_front();
      n_vec++;
      if (obs_a() !== e) begin
        n_bad++;
        $display("FAIL ignore_c%0d got %b want %b", k, obs_a(), e);
      end
      n_vec++;
      if (a_echo !== echo_a_exp) begin
        n_bad++;
        $display("FAIL ignore_echo_c%0d got %h want %h", k, a_echo, echo_a_exp);
      end
      // A foreign command during the shift phase must be dropped.
      if (k == 5) begin
        a_w0 = 4'hF; a_w1 = 4'hF; a_open = 1'b1; a_valid = 1'b1;
      end
      if (k == 7) a_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] f;
    logic [5:0]  e;
    f = frame_of(4'h7, 4'h7, 1'b1);
    send_a(4'h7, 4'h7, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) a_valid = 1'b0;
      e = model(k, 1, 0, f);
      n_vec++;
      if (obs_a() !== e) begin
        n_bad++;
        $display("FAIL rstmid_c%0d got %b want %b", k, obs_a(), e);
      end
    end
    rst = 1'b1;
    #1;
    void'(sb_a.pop_back());
    echo_a_exp = 16'h0000;
    n_vec++;
    if ({obs_a(), a_echo} !== {6'b100000, 16'h0000}) begin
      n_bad++;
      $display("FAIL rstmid_async got %b/%h want 100000/0000", obs_a(), a_echo);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    f = frame_of(4'h3, 4'hC, 1'b1);
    send_a(4'h3, 4'hC, 1'b1);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 1) a_valid = 1'b0;
      e = model(k, 1, 0, f);
      if (e[0] && sb_a.size() > 0) echo_a_exp = sb_a.pop_front();
      n_vec++;
      if (obs_a() !== e) begin
        n_bad++;
        $display("FAIL rstmid_new_c%0d got %b want %b", k, obs_a(), e);
      end
      n_vec++;
      if (a_echo !== echo_a_exp) begin
        n_bad++;
        $display("FAIL rstmid_echo_c%0d got %h want %h", k, a_echo, echo_a_exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] f;
    logic [5:0]  e;
    int          dones;
    dones = 0;
    f = frame_of(4'h2, 4'h4, 1'b0);
    @(negedge clk);
    a_w0 = 4'h2; a_w1 = 4'h4; a_open = 1'b0; a_valid = 1'b1;
    for (int n = 0; n < 3; n++) sb_a.push_back(f);
    @(posedge clk);
    for (int k = 1; k <= 57; k++) begin
      @(negedge clk);
      e = model((k - 1) % 19 + 1, 1, 0, f);
      if (e[0] && sb_a.size() > 0) echo_a_exp = sb_a.pop_front();
      if (a_done === 1'b1) dones++;
      n_vec++;
      if (obs_a() !== e) begin
        n_bad++;
        $display("FAIL b2b_c%0d got %b want %b", k, obs_a(), e);
      end
      n_vec++;
      if (a_echo !== echo_a_exp) begin
        n_bad++;
        $display("FAIL b2b_echo_c%0d got %h want %h", k, a_echo, echo_a_exp);
      end
      // Third accept happens at the edge closing cycle 38.
      if (k == 39) a_valid = 1'b0;
    end
    n_vec++;
    if (dones !== 3) begin
      n_bad++;
      $display("FAIL b2b_done_count got %0d want 3", dones);
    end
  endtask

  initial begin
    rst = 1'b0;
    a_valid = 1'b0; a_w0 = 4'h0; a_w1 = 4'h0; a_open = 1'b0;
    b_valid = 1'b0; b_w0 = 4'h0; b_w1 = 4'h0; b_open = 1'b0;
    test_reset();
    test_basic();
    test_gap();
    test_echo();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
